rs_syndrome_unit: RTL and testbench
===================================

# rs_syndrome_unit

Parametrised Reed-Solomon syndrome generator: the first stage of the generalised RS decode path that supersedes the fixed RS(7,3) decoder. It accepts received symbols serially over a valid/ready handshake, highest-degree symbol first. It accumulates 2T syndromes over GF(2^M) using Horner's rule and presents them, with an error-detected flag, on a held output handshake. Downstream key-equation and Chien stages consume the output; the defaults reproduce the existing RS(7,3) over GF(8) configuration.

## Interface
- M, default 3: symbol width in bits; field is GF(2^M).
- N, default 7: codeword length in symbols; legal range 2T < N <= 2^M-1.
- T, default 2: correctable symbols; 2T syndromes are produced.
- PRIM_POLY, default 11 (x^3+x+1): primitive polynomial, M+1 bits, with bit M set.
- FCR, default 1: first consecutive root; syndrome j (j = 0..2T-1) is evaluated at alpha^(FCR+j), where alpha = 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  symbol acceptance enable; gates sym_ready.
- clear  in  1  synchronous abandon of the current codeword.
- sym_in  in  M  received symbol.
- sym_valid  in  1  sym_in is valid.
- sym_ready  out  1  block accepts a symbol this cycle.
- synd  out  2T*M  syndromes; S at alpha^(FCR+j) occupies bits [j*M +: M].
- synd_valid  out  1  synd and error_detected are valid and held.
- synd_ready  in  1  consumer takes the syndromes.
- error_detected  out  1  OR-reduction of all syndromes; valid with synd_valid.

## Operation
- Two states:
  - ACCUM: collecting symbols. sym_ready = enable.
  - HOLD: results presented. sym_ready = 0.
- Symbol counter cnt has width clog2(N), range 0..N-1.
- Accept = sym_valid & sym_ready, evaluated in ACCUM.
- On accept with cnt == 0: every S_j <= sym_in. The first symbol overwrites the previous codeword's syndromes; no separate clear cycle is needed.
- On accept with cnt > 0: S_j <= (S_j * alpha^(FCR+j)) XOR sym_in.
- Constant multiply: FCR+j repeated xtime steps. Each xtime is a left shift; if the bit shifted out of bit M-1 is 1, XOR with PRIM_POLY[M-1:0]. All results are exactly M bits.
- On accept with cnt == N-1: go to HOLD, cnt <= 0, synd_valid <= 1, error_detected <= |(final syndromes).
- HOLD: synd and error_detected are held stable. When synd_ready = 1, return to ACCUM and drop synd_valid.
- sym_valid low, or enable low, mid-codeword: state, cnt and syndromes are frozen.
- clear has priority over accept and over the output handshake. It forces ACCUM, cnt = 0, all S_j = 0, synd_valid = 0 and error_detected = 0.
- Reset values: state ACCUM, cnt 0, synd all zeros, synd_valid 0, error_detected 0. sym_ready follows enable combinationally from reset onward.
- Reset asserted mid-codeword discards the partial codeword immediately (asynchronous).

## Timing
- Throughput: one symbol per cycle in ACCUM.
- Minimum codeword period is N+1 cycles: N accepts plus at least one HOLD cycle.
- Latency: synd_valid rises on the clock edge that accepts symbol N-1, so it is visible in the cycle after the last accept.
- synd_valid goes low on the edge where synd_valid & synd_ready = 1. sym_ready is 1 (if enable = 1) in the following cycle.
- No combinational path from sym_in to synd. sym_ready depends only on state and enable, never on sym_valid.
- Multiply-accumulate is a single cycle: 2T parallel constant multipliers followed by XOR.

## Test plan
- Reset: hold reset, then release with enable = 1 -> synd = 12'h000, synd_valid = 0, error_detected = 0, sym_ready = 1.
- All-zero codeword, 7 back-to-back symbols of 0, synd_ready = 1 -> synd_valid high for exactly 1 cycle after the 7th accept; synd = 12'h000; error_detected = 0. A second codeword is accepted in the following cycle.
- Error value 1 at degree 0 (symbols 0,0,0,0,0,0,1) -> S1..S4 = 1,1,1,1, synd = 12'h249, error_detected = 1.
- Error value 1 at degree 1 (symbols 0,0,0,0,0,1,0) -> S1..S4 = 2,4,3,6, synd = 12'hCE2, error_detected = 1.
- Backpressure and gaps, repeating the degree-1 codeword:
  - Drop sym_valid for 2 cycles and enable for 1 cycle mid-codeword -> result still 12'hCE2.
  - Hold synd_ready low for 5 cycles -> synd stable and sym_ready = 0 throughout.
- Clear and reset:
  - Accept 3 nonzero symbols, assert clear, then send the all-zero codeword -> synd = 12'h000.
  - Pulse reset after 4 symbols -> outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/rs_syndrome_unit.sv
// Reed-Solomon syndrome generator: accumulates 2T syndromes over GF(2^M) with
// Horner's rule, one received symbol per cycle, highest degree first.
module rs_syndrome_unit #(
  parameter int M         = 3,
  parameter int N         = 7,
  parameter int T         = 2,
  parameter int PRIM_POLY = 11,
  parameter int FCR       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [M-1:0]     sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic [2*T*M-1:0] synd,
  output logic             synd_valid,
  input  logic             synd_ready,
  output logic             error_detected
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MAXP  = FCR + 2*T - 1;
  localparam logic [M-1:0] POLY_LO = M'(PRIM_POLY);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2*T-1:0][M-1:0]     syn_q, syn_d;
  logic                      vld_q, vld_d;
  logic                      err_q, err_d;
  logic                      accept;

  function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
    xtime = {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY_LO : '0);
  endfunction

  // Multiply by alpha^k as k chained xtime steps; loop bound is static.
  function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] v, input int k);
    logic [M-1:0] r;
    r = v;
    for (int i = 0; i < MAXP; i++) begin
      if (i < k) r = xtime(r);
    end
    return r;
  endfunction

  assign sym_ready      = (state_q == ACCUM) & enable;
  assign accept         = sym_valid & sym_ready;
  assign synd           = syn_q;
  assign synd_valid     = vld_q;
  assign error_detected = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    syn_d   = syn_q;
    vld_d   = vld_q;
    err_d   = err_q;
    if (clear) begin
      state_d = ACCUM;
      cnt_d   = '0;
      syn_d   = '0;
      vld_d   = 1'b0;
      err_d   = 1'b0;
    end else if (state_q == ACCUM) begin
      if (accept) begin
        // First symbol overwrites the previous codeword's syndromes.
        for (int j = 0; j < 2*T; j++) begin
          syn_d[j] = (cnt_q == '0) ? sym_in : (mul_alpha_pow(syn_q[j], FCR + j) ^ sym_in);
        end
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          vld_d   = 1'b1;
          err_d   = |syn_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (synd_ready) begin
      state_d = ACCUM;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      syn_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      syn_q   <= syn_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rs_syndrome_unit.sv
// Bench for rs_syndrome_unit in the default RS(7,3) / GF(8) configuration.
module tb_rs_syndrome_unit;

  localparam int M  = 3;
  localparam int N  = 7;
  localparam int T  = 2;
  localparam int SW = 2*T*M;

  logic          clk = 1'b0;
  logic          reset, enable, clear;
  logic [M-1:0]  sym_in;
  logic          sym_valid, sym_ready;
  logic [SW-1:0] synd;
  logic          synd_valid, synd_ready, error_detected;

  rs_syndrome_unit #(.M(M), .N(N), .T(T), .PRIM_POLY(11), .FCR(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .synd(synd), .synd_valid(synd_valid), .synd_ready(synd_ready),
    .error_detected(error_detected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*M-1:0] syms;
    logic [SW-1:0]  synd;
    logic           err;
  } vec_t;

  typedef struct {
    logic [SW-1:0] synd;
    logic          err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[5];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic took = 1'b0;
  logic hs_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: direct evaluation r(alpha^k) = XOR of r_d * alpha^(k*d).
  function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r ^= x;
      x = {x[M-2:0], 1'b0} ^ (x[M-1] ? 3'b011 : 3'b000);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] gpow(input int k);
    logic [M-1:0] r;
    r = 3'd1;
    for (int i = 0; i < k; i++) r = gmul(r, 3'd2);
    return r;
  endfunction

  function automatic logic [SW-1:0] model(input logic [N*M-1:0] w);
    logic [SW-1:0] s;
    logic [M-1:0]  acc;
    s = '0;
    for (int j = 0; j < 2*T; j++) begin
      acc = '0;
      for (int i = 0; i < N; i++)
        acc ^= gmul(w[(N-1-i)*M +: M], gpow((1 + j) * (N-1-i)));
      s[j*M +: M] = acc;
    end
    return s;
  endfunction

  // One cycle: sample at negedge (scoreboard pops on output handshake), return at posedge+1.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    took    = sym_valid && sym_ready;
    hs_seen = synd_valid && synd_ready;
    if (hs_seen && !reset) begin
      if (sbq.size() == 0) begin
        check("unexpected_result", 32'(synd), 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        check("sb_synd", 32'(synd), 32'(e.synd));
        check("sb_err", 32'(error_detected), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [M-1:0] s);
    int n;
    sym_in    = s;
    sym_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!took && n < 50);
    if (!took) check("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_cw(input logic [N*M-1:0] w, input logic [SW-1:0] es, input logic ee);
    exp_t e;
    e.synd = es;
    e.err  = ee;
    sbq.push_back(e);
    for (int i = 0; i < N; i++) send_sym(w[(N-1-i)*M +: M]);
    sym_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!hs_seen && n < 40);
    if (!hs_seen) check("result_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic [N*M-1:0] w;
    logic [SW-1:0]  held;

    vecs[0] = '{syms: 21'h000000, synd: 12'h000, err: 1'b0};
    vecs[1] = '{syms: 21'h000001, synd: 12'h249, err: 1'b1};
    vecs[2] = '{syms: 21'h000008, synd: 12'hCE2, err: 1'b1};
    vecs[3] = '{syms: 21'h040000, synd: 12'h7BD, err: 1'b1};
    vecs[4] = '{syms: 21'h0000C0, synd: 12'hD0F, err: 1'b1};

    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    sym_in = '0; sym_valid = 1'b0; synd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_synd", 32'(synd), 32'h0);
    check("rst_synd_valid", 32'(synd_valid), 32'h0);
    check("rst_err", 32'(error_detected), 32'h0);
    check("rst_sym_ready", 32'(sym_ready), 32'h1);

    foreach (vecs[k]) send_cw(vecs[k].syms, vecs[k].synd, vecs[k].err);
    wait_result();

    for (int r = 0; r < 6; r++) begin
      w = N*M'({$urandom, $urandom});
      send_cw(w, model(w), |model(w));
    end
    wait_result();

    // Zero codeword: valid for exactly one cycle, next codeword starts straight after.
    send_cw(21'h0, 12'h000, 1'b0);
    check("zero_valid_hi", 32'(synd_valid), 32'h1);
    check("zero_ready_lo", 32'(sym_ready), 32'h0);
    begin
      exp_t e;
      e.synd = 12'h000;
      e.err  = 1'b0;
      sbq.push_back(e);
    end
    sym_in = '0; sym_valid = 1'b1;
    tick();
    check("zero_valid_drop", 32'(synd_valid), 32'h0);
    check("zero_ready_back", 32'(sym_ready), 32'h1);
    tick();
    check("b2b_accept", 32'(took), 32'h1);
    for (int i = 1; i < N; i++) send_sym('0);
    sym_valid = 1'b0;
    wait_result();

    // Gaps, enable drop and output backpressure on the degree-1 codeword.
    synd_ready = 1'b0;
    begin
      exp_t e;
      e.synd = 12'hCE2;
      e.err  = 1'b1;
      sbq.push_back(e);
    end
    send_sym(0); send_sym(0); send_sym(0);
    sym_valid = 1'b0;
    tick(); tick();
    send_sym(0);
    enable = 1'b0; sym_in = 3'd5; sym_valid = 1'b1;
    tick();
    check("enable_gate", 32'(took), 32'h0);
    check("enable_ready", 32'(sym_ready), 32'h0);
    enable = 1'b1;
    send_sym(0); send_sym(1); send_sym(0);
    held = synd;
    check("bp_synd", 32'(held), 32'hCE2);
    sym_in = 3'd5; sym_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_synd", 32'(synd), 32'(held));
      check("bp_hold_valid", 32'(synd_valid), 32'h1);
      check("bp_hold_ready", 32'(sym_ready), 32'h0);
    end
    sym_valid = 1'b0;
    synd_ready = 1'b1;
    wait_result();

    // Clear abandons a partial codeword.
    send_sym(3'd5); send_sym(3'd3); send_sym(3'd7);
    sym_valid = 1'b0;
    check("partial_nonzero", 32'(synd != '0), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_synd", 32'(synd), 32'h0);
    check("clear_valid", 32'(synd_valid), 32'h0);
    send_cw(21'h0, 12'h000, 1'b0);
    wait_result();

    // Asynchronous reset mid-codeword.
    send_sym(3'd1); send_sym(3'd2); send_sym(3'd3); send_sym(3'd4);
    sym_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_synd", 32'(synd), 32'h0);
    check("arst_valid", 32'(synd_valid), 32'h0);
    check("arst_err", 32'(error_detected), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    send_cw(21'h000008, 12'hCE2, 1'b1);
    wait_result();

    check("sb_empty", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
